uart_ram_ctrl: RTL and testbench
================================

// Module: uart_ram_ctrl
// PURPOSE
//  Packet sequencer between the UART receiver, the byte-wide RAM and the UART transmitter.
//  Decodes received bytes into write packets (host -> RAM) and read packets (RAM -> host).
//  Owns the RAM port and schedules RAM writes, RAM reads and TX byte launches one at a time.
//  Write packet: 0xAA, addr, len, len data bytes. Read packet: 0x55, addr, len.
// PARAMETERS
//  AW       8        RAM address width (1..8); the addr byte is truncated to its low AW bits
//  TIMEOUT  2604000  clk cycles allowed between bytes inside a packet (~50 ms at 50 MHz)
// PORTS
//  clk        in   1   system clock (50 MHz)
//  rst_n      in   1   asynchronous active-low reset
//  rx_data    in   8   received byte from UART receiver
//  rx_int     in   1   high while receiver is busy; falling edge = byte complete
//  ram_we     out  1   RAM write enable, one-cycle pulse
//  ram_addr   out  AW  RAM address
//  ram_wdata  out  8   RAM write data
//  ram_rdata  in   8   RAM read data, valid 1 cycle after ram_addr is presented
//  tx_data    out  8   byte to transmit, held stable from tx_start until the next tx_start
//  tx_start   out  1   one-cycle launch pulse to UART transmitter
//  tx_busy    in   1   transmitter busy
//  busy       out  1   high in every state except IDLE
//  err        out  1   one-cycle pulse on timeout abort
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, internal address, count and timer 0.
//  Reset is async and may assert mid-packet: abort immediately, no further RAM/TX activity.
//  Byte strobe: rx_int registered to rx_int_d; byte_v = rx_int_d & ~rx_int.
//   rx_data is sampled in the byte_v cycle.
//  States and transitions:
//   IDLE:     byte_v & 0xAA -> W_ADDR; byte_v & 0x55 -> R_ADDR; any other byte is ignored.
//   W_ADDR:   byte_v -> addr <= byte[AW-1:0], then W_LEN.
//   R_ADDR:   byte_v -> addr <= byte[AW-1:0], then R_LEN.
//   W_LEN:    byte_v -> cnt <= byte; if byte==0 -> IDLE, else W_DATA.
//   R_LEN:    byte_v -> cnt <= byte; if byte==0 -> IDLE, else RD.
//   W_DATA:   on byte_v, in the same cycle: ram_we=1, ram_wdata=byte, ram_addr=addr.
//             Next cycle: addr+1, cnt-1. If cnt was 1 -> IDLE.
//   RD:       drive ram_addr=addr, then RD_WAIT (1 cycle for RAM latency).
//   RD_WAIT:  latch ram_rdata into tx_data, then TX_GO.
//   TX_GO:    wait while tx_busy=1; when tx_busy=0, pulse tx_start for 1 cycle, then TX_HOLD.
//   TX_HOLD:  2-cycle guard in which tx_busy is ignored. Then addr+1, cnt-1;
//             cnt was 1 -> IDLE, else RD.
//  Address arithmetic: addr wraps modulo 2^AW; cnt is 8 bits, len 1..255.
//  Timeout:
//   - timer clears on every byte_v and on entry to W_ADDR/R_ADDR/W_LEN/R_LEN/W_DATA.
//   - timer increments in those states; reaching TIMEOUT -> err pulse, state IDLE.
//   - bytes already written stay in RAM.
//  RX bytes arriving in RD/RD_WAIT/TX_GO/TX_HOLD are discarded; they do not start a new packet.
//  ram_we is never asserted outside W_DATA. RAM writes and reads never overlap.
//  ram_addr holds its last value when idle.
// TESTING
//  1 Write packet AA 10 03 11 22 33 -> three ram_we pulses:
//    addr 0x10=0x11, 0x11=0x22, 0x12=0x33; busy low after the last write.
//  2 Read packet 55 10 03 after test 1, model tx_busy high 20 cycles after each tx_start
//    -> tx_start x3 with tx_data 0x11, 0x22, 0x33, each issued only while tx_busy=0.
//  3 Wrap, AW=8: AA FE 03 01 02 03 -> writes at FE, FF, 00; no write to 0x100 or FD.
//  4 Zero length: AA 20 00, then 55 20 00 -> no ram_we, no tx_start, busy back to 0.
//  5 Timeout, TIMEOUT=100: AA 40, then silence -> err pulse exactly once;
//    next byte 0x40 in IDLE is ignored.
//  6 Reset mid-packet: assert rst_n low during the W_DATA byte of AA 00 02 -> outputs 0 at once;
//    after release, a fresh packet AA 05 01 7E writes 0x7E at 0x05.
//  7 Noise: bytes 00 FF 13 in IDLE -> no state change; bytes during readback -> no extra RAM writes.

Source files
------------

// File: rtl/uart_ram_ctrl.sv
// Packet sequencer between UART RX, a byte-wide RAM and UART TX.
// Write packet: AA addr len data*len. Read packet: 55 addr len, bytes returned over TX.
module uart_ram_ctrl #(
   parameter int AW      = 8,
   parameter int TIMEOUT = 2604000
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [7:0]    rx_data,
   input  logic          rx_int,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [7:0]    ram_wdata,
   input  logic [7:0]    ram_rdata,
   output logic [7:0]    tx_data,
   output logic          tx_start,
   input  logic          tx_busy,
   output logic          busy,
   output logic          err
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [3:0] {
      IDLE, W_ADDR, W_LEN, W_DATA, R_ADDR, R_LEN, RD, RD_WAIT, TX_GO, TX_HOLD
   } state_t;

   state_t          state_q, state_d;
   logic            rx_int_q;
   logic [AW-1:0]   addr_q, addr_d;
   logic [AW-1:0]   ram_addr_q, ram_addr_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic            hold_q, hold_d;
   logic            byte_v;
   logic            timed;
   logic            timeout;

   assign byte_v  = rx_int_q & ~rx_int;
   assign timed   = state_q inside {W_ADDR, W_LEN, W_DATA, R_ADDR, R_LEN};
   assign timeout = timed && !byte_v && (timer_q == TW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         rx_int_q   <= 1'b0;
         addr_q     <= '0;
         ram_addr_q <= '0;
         cnt_q      <= '0;
         tx_data_q  <= '0;
         timer_q    <= '0;
         hold_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rx_int_q   <= rx_int;
         addr_q     <= addr_d;
         ram_addr_q <= ram_addr_d;
         cnt_q      <= cnt_d;
         tx_data_q  <= tx_data_d;
         timer_q    <= timer_d;
         hold_q     <= hold_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      ram_addr_d = ram_addr_q;
      cnt_d      = cnt_q;
      tx_data_d  = tx_data_q;
      hold_d     = 1'b0;
      ram_we     = 1'b0;
      ram_wdata  = 8'h00;
      ram_addr   = ram_addr_q;
      tx_start   = 1'b0;
      err        = 1'b0;

      case (state_q)
         IDLE: begin
            if (byte_v && rx_data == 8'hAA) state_d = W_ADDR;
            else if (byte_v && rx_data == 8'h55) state_d = R_ADDR;
         end
         W_ADDR: begin
            if (byte_v) begin
               addr_d  = rx_data[AW-1:0];
               state_d = W_LEN;
            end
         end
         R_ADDR: begin
            if (byte_v) begin
               addr_d  = rx_data[AW-1:0];
               state_d = R_LEN;
            end
         end
         W_LEN: begin
            if (byte_v) begin
               cnt_d   = rx_data;
               state_d = (rx_data == 8'h00) ? IDLE : W_DATA;
            end
         end
         R_LEN: begin
            if (byte_v) begin
               cnt_d   = rx_data;
               state_d = (rx_data == 8'h00) ? IDLE : RD;
            end
         end
         W_DATA: begin
            // Write is issued combinationally in the strobe cycle itself
            if (byte_v) begin
               ram_we     = 1'b1;
               ram_wdata  = rx_data;
               ram_addr   = addr_q;
               ram_addr_d = addr_q;
               addr_d     = addr_q + AW'(1);
               cnt_d      = cnt_q - 8'd1;
               if (cnt_q == 8'd1) state_d = IDLE;
            end
         end
         RD: begin
            ram_addr   = addr_q;
            ram_addr_d = addr_q;
            state_d    = RD_WAIT;
         end
         RD_WAIT: begin
            tx_data_d = ram_rdata;
            state_d   = TX_GO;
         end
         TX_GO: begin
            if (!tx_busy) begin
               tx_start = 1'b1;
               state_d  = TX_HOLD;
            end
         end
         TX_HOLD: begin
            // Transmitter may not have raised tx_busy yet; ignore it for two cycles
            hold_d = 1'b1;
            if (hold_q) begin
               hold_d  = 1'b0;
               addr_d  = addr_q + AW'(1);
               cnt_d   = cnt_q - 8'd1;
               state_d = (cnt_q == 8'd1) ? IDLE : RD;
            end
         end
         default: state_d = IDLE;
      endcase

      if (timeout) begin
         err     = 1'b1;
         state_d = IDLE;
      end
   end

   always_comb begin
      timer_d = timer_q + TW'(1);
      if (byte_v || !timed || state_d != state_q) timer_d = '0;
   end

   assign tx_data = tx_data_q;
   assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_ram_ctrl.sv
// Bench for uart_ram_ctrl: RAM and transmitter models, scoreboard queues for
// expected RAM writes and TX bytes, a packet table plus hand-written corner cases.
module tb_uart_ram_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] rx_data;
   logic       rx_int;
   logic       ram_we;
   logic [7:0] ram_addr;
   logic [7:0] ram_wdata;
   logic [7:0] ram_rdata;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       tx_busy;
   logic       busy;
   logic       err;

   int nvec  = 0;
   int nfail = 0;
   int err_cnt = 0;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] d;
   } wr_t;
   wr_t        exp_wr[$];
   logic [7:0] exp_tx[$];
   logic [7:0] mem[256];
   logic [7:0] sh[256];
   logic [5:0] bcnt = '0;

   typedef struct {
      logic [63:0] bytes;
      int          n;
   } pkt_t;
   pkt_t tbl[7];

   uart_ram_ctrl #(.AW(8), .TIMEOUT(100)) dut (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_int(rx_int),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .tx_data(tx_data), .tx_start(tx_start),
      .tx_busy(tx_busy), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   // RAM with one cycle read latency
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   // Transmitter stays busy for 20 cycles after each launch
   always @(posedge clk) begin
      if (tx_start) bcnt <= 6'd20;
      else if (bcnt != 0) bcnt <= bcnt - 6'd1;
   end
   assign tx_busy = (bcnt != 0);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (ram_we) begin
         if (exp_wr.size() == 0) chk("unexpected_we", {ram_addr, ram_wdata}, 32'hFFFF_FFFF);
         else begin
            wr_t w;
            w = exp_wr.pop_front();
            chk("we_addr_data", {ram_addr, ram_wdata}, {w.a, w.d});
         end
      end
      if (tx_start) begin
         chk("tx_start_while_busy", {31'd0, tx_busy}, 32'd0);
         if (exp_tx.size() == 0) chk("unexpected_tx", {24'd0, tx_data}, 32'hFFFF_FFFF);
         else chk("tx_data", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
      end
      if (err) err_cnt++;
   end

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk);
      #1 rx_data = b;
      rx_int = 1'b1;
      repeat (3) @(posedge clk);
      #1 rx_int = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   task automatic wait_idle(input string name);
      int t = 0;
      while (busy && t < 1000) begin
         @(posedge clk);
         t++;
      end
      #1;
      chk({name, "_idle"}, {31'd0, busy}, 32'd0);
      chk({name, "_wr_left"}, exp_wr.size(), 32'd0);
      chk({name, "_tx_left"}, exp_tx.size(), 32'd0);
   endtask

   function automatic logic [7:0] pbyte(input logic [63:0] v, input int i);
      return v[63-8*i -: 8];
   endfunction

   task automatic push_exp(input logic [63:0] v, input int n);
      logic [7:0] h, a, l;
      h = pbyte(v, 0);
      a = pbyte(v, 1);
      l = pbyte(v, 2);
      if (n >= 3 && h == 8'hAA) begin
         for (int k = 0; k < int'(l) && 3 + k < n; k++) begin
            exp_wr.push_back('{a: a + 8'(k), d: pbyte(v, 3 + k)});
            sh[a + 8'(k)] = pbyte(v, 3 + k);
         end
      end else if (n >= 3 && h == 8'h55) begin
         for (int k = 0; k < int'(l); k++) exp_tx.push_back(sh[a + 8'(k)]);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i] = 8'h00;
         sh[i]  = 8'h00;
      end
      tbl[0] = '{64'hAA10_0311_2233_0000, 6};
      tbl[1] = '{64'h5510_0300_0000_0000, 3};
      tbl[2] = '{64'hAAFE_0301_0203_0000, 6};
      tbl[3] = '{64'hAA20_0000_0000_0000, 3};
      tbl[4] = '{64'h5520_0000_0000_0000, 3};
      tbl[5] = '{64'h00FF_1300_0000_0000, 3};
      tbl[6] = '{64'h55FE_0300_0000_0000, 3};

      rst_n = 1'b0;
      rx_int = 1'b0;
      rx_data = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
      chk("rst_ram_addr", {24'd0, ram_addr}, 32'd0);
      chk("rst_ram_wdata", {24'd0, ram_wdata}, 32'd0);
      chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
      chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++) begin
         push_exp(tbl[i].bytes, tbl[i].n);
         for (int j = 0; j < tbl[i].n; j++) send_byte(pbyte(tbl[i].bytes, j));
         wait_idle($sformatf("pkt%0d", i));
      end
      chk("no_err_in_table", err_cnt, 32'd0);

      // Bytes arriving during readback must be discarded
      push_exp(64'h5510_0300_0000_0000, 3);
      send_byte(8'h55);
      send_byte(8'h10);
      send_byte(8'h03);
      send_byte(8'hAA);
      send_byte(8'h33);
      wait_idle("rd_noise");
      repeat (10) @(posedge clk);
      #1 chk("rd_noise_busy", {31'd0, busy}, 32'd0);

      // Timeout after AA 40, then a stray 0x40 in IDLE
      send_byte(8'hAA);
      send_byte(8'h40);
      begin
         int t = 0;
         while (err_cnt == 0 && t < 300) begin
            @(posedge clk);
            t++;
         end
      end
      repeat (50) @(posedge clk);
      #1;
      chk("timeout_err_once", err_cnt, 32'd1);
      chk("timeout_busy", {31'd0, busy}, 32'd0);
      send_byte(8'h40);
      #1;
      chk("stray_busy", {31'd0, busy}, 32'd0);
      chk("stray_no_err", err_cnt, 32'd1);

      // Reset during the first data byte of AA 00 02
      send_byte(8'hAA);
      send_byte(8'h00);
      send_byte(8'h02);
      @(posedge clk);
      #1 rx_data = 8'h09;
      rx_int = 1'b1;
      repeat (3) @(posedge clk);
      #1 rx_int = 1'b0;
      #1 chk("pre_rst_we", {31'd0, ram_we}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_we", {31'd0, ram_we}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_addr", {24'd0, ram_addr}, 32'd0);
      chk("mid_rst_wdata", {24'd0, ram_wdata}, 32'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      push_exp(64'hAA05_017E_0000_0000, 4);
      send_byte(8'hAA);
      send_byte(8'h05);
      send_byte(8'h01);
      send_byte(8'h7E);
      wait_idle("post_rst");
      chk("post_rst_mem", {24'd0, mem[8'h05]}, 32'h7E);
      chk("rst_no_write_00", {24'd0, mem[8'h00]}, {24'd0, sh[8'h00]});

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
